// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, word-length encodings and helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_rx_bit_vote.sv
// Per-bit oversample tick counter with 2-of-3 majority vote around mid-bit.
module uart_rx_bit_vote #(
  parameter int OVERSAMPLE = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic rxclk,
  input  logic clr,
  input  logic sin,
  output logic bit_valid,
  output logic bit_end,
  output logic bit_val
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          s0_q, s0_d, s1_q, s1_d;

  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    if (clr) begin
      cnt_d = '0;
      s0_d  = 1'b0;
      s1_d  = 1'b0;
    end else if (rxclk) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(M - 2)) s0_d = sin;
      if (cnt_q == CW'(M - 1)) s1_d = sin;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
    end
  end

  // Strobes deliberately ignore clr: clr is derived from the next state,
  // which itself depends on these strobes.
  assign bit_valid = rxclk & (cnt_q == CW'(M));
  assign bit_end   = rxclk & (cnt_q == CW'(OVERSAMPLE - 1));
  assign bit_val   = (s0_q & s1_q) | (s0_q & sin) | (s1_q & sin);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, data/parity/stop sampling, error and break flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       RXCLEAR,
  input  logic       SIN,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);
  rx_state_t  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shadow_q, shadow_d;
  logic [1:0] wls_q, wls_d;
  logic       pen_q, pen_d, eps_q, eps_d, sp_q, sp_d;
  logic       par_q, par_d;
  logic [7:0] dout_q, dout_d;
  logic       pe_q, pe_d, fe_q, fe_d, bi_q, bi_d, fin_q, fin_d;

  logic       bit_valid, bit_end, bit_val;
  logic [3:0] nbits;
  logic [2:0] last_idx;
  logic       exp_par, brk;

  uart_rx_bit_vote #(.OVERSAMPLE(OVERSAMPLE)) u_vote (
    .CLK      (CLK),
    .RST      (RST),
    .rxclk    (RXCLK),
    .clr      (state_d == IDLE),
    .sin      (SIN),
    .bit_valid(bit_valid),
    .bit_end  (bit_end),
    .bit_val  (bit_val)
  );

  assign nbits    = wls_to_bits(wls_q);
  assign last_idx = nbits[2:0] - 3'd1;
  // Unused shadow bits are zero, so reducing the whole byte is safe.
  assign exp_par  = sp_q ? ~eps_q : (eps_q ? ^shadow_q : ~^shadow_q);
  assign brk      = ~bit_val & (shadow_q == 8'h00) & ~(pen_q & par_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    wls_d    = wls_q;
    pen_d    = pen_q;
    eps_d    = eps_q;
    sp_d     = sp_q;
    par_d    = par_q;
    dout_d   = dout_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    bi_d     = bi_q;
    fin_d    = 1'b0;
    if (RXCLEAR) begin
      state_d  = IDLE;
      idx_d    = '0;
      shadow_d = '0;
      par_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (RXCLK && !SIN) state_d = START;
        START:
          if (bit_valid && bit_val) begin
            state_d = IDLE;
          end else if (bit_end) begin
            state_d  = DATA;
            idx_d    = '0;
            shadow_d = '0;
            par_d    = 1'b0;
            wls_d    = WLS;
            pen_d    = PEN;
            eps_d    = EPS;
            sp_d     = SP;
          end
        DATA: begin
          if (bit_valid) shadow_d[idx_q] = bit_val;
          if (bit_end) begin
            if (idx_q == last_idx) state_d = pen_q ? PARITY : STOP;
            else                   idx_d   = idx_q + 3'd1;
          end
        end
        PARITY: begin
          if (bit_valid) par_d = bit_val;
          if (bit_end)   state_d = STOP;
        end
        STOP:
          if (bit_valid) begin
            dout_d  = shadow_q;
            fe_d    = ~bit_val;
            pe_d    = pen_q & (par_q != exp_par);
            bi_d    = brk;
            fin_d   = 1'b1;
            state_d = (brk || !bit_val) ? BRK_WAIT : IDLE;
          end
        BRK_WAIT:
          if (RXCLK && SIN) state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      wls_q    <= WLS_8;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      sp_q     <= 1'b0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      bi_q     <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      wls_q    <= wls_d;
      pen_q    <= pen_d;
      eps_q    <= eps_d;
      sp_q     <= sp_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      bi_q     <= bi_d;
      fin_q    <= fin_d;
    end
  end

  assign DOUT       = dout_q;
  assign PE         = pe_q;
  assign FE         = fe_q;
  assign BI         = bi_q;
  assign RXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames, parity modes, false start, framing, break, aborts.
module tb_uart_rx_frame;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXCLK = 1'b0;
  logic       RXCLEAR = 1'b0;
  logic       SIN = 1'b1;
  logic [1:0] WLS = 2'b11;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;

  int n_chk = 0;
  int n_fail = 0;
  int cur_tick = 0;
  int fin_cnt = 0;
  int fin_tick = 0;
  int st = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame #(.OVERSAMPLE(16)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR), .SIN(SIN),
    .WLS(WLS), .PEN(PEN), .EPS(EPS), .SP(SP),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .RXFINISHED(RXFINISHED)
  );

  always @(negedge CLK) begin
    if (RXFINISHED) begin
      fin_cnt  <= fin_cnt + 1;
      fin_tick <= cur_tick;
    end
  end

  // One baud-enable tick: RXCLK high for one CLK, low for one CLK.
  task automatic tick();
    @(negedge CLK);
    cur_tick = cur_tick + 1;
    RXCLK = 1'b1;
    @(negedge CLK);
    RXCLK = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_bit, input logic scramble);
    SIN = 1'b0;
    st = cur_tick + 1;
    ticks(16);
    if (scramble) begin
      WLS = 2'b11;
      PEN = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      SIN = data[i];
      ticks(16);
    end
    if (par_en) begin
      SIN = par_bit;
      ticks(16);
    end
    SIN = stop_bit;
    ticks(16);
    SIN = 1'b1;
    ticks(4);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_chk++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", DOUT); end
    n_chk++; if (PE !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", PE); end
    n_chk++; if (FE !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", FE); end
    n_chk++; if (BI !== 1'b0) begin n_fail++; $display("FAIL reset_bi: got %b want 0", BI); end
    n_chk++; if (RXFINISHED !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %b want 0", RXFINISHED); end
  endtask

  task automatic test_8n1();
    int f0;
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    f0 = fin_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (DOUT !== 8'hA5) begin n_fail++; $display("FAIL 8n1_dout: got %h want a5", DOUT); end
    n_chk++; if ({PE, FE, BI} !== 3'b000) begin n_fail++; $display("FAIL 8n1_flags: got %b want 000", {PE, FE, BI}); end
    n_chk++; if (fin_cnt - f0 != 1) begin n_fail++; $display("FAIL 8n1_pulses: got %0d want 1", fin_cnt - f0); end
    n_chk++; if (fin_tick - st != 152) begin n_fail++; $display("FAIL 8n1_latency: got %0d want 152", fin_tick - st); end
  endtask

  task automatic test_7e1();
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    n_chk++; if (DOUT !== 8'h41) begin n_fail++; $display("FAIL 7e1_dout_a: got %h want 41", DOUT); end
    n_chk++; if (PE !== 1'b1) begin n_fail++; $display("FAIL 7e1_pe_bad: got %b want 1", PE); end
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    n_chk++; if (DOUT !== 8'h41) begin n_fail++; $display("FAIL 7e1_dout_b: got %h want 41", DOUT); end
    n_chk++; if (PE !== 1'b0) begin n_fail++; $display("FAIL 7e1_pe_good: got %b want 0", PE); end
    // Odd parity: 0x41 has two ones, so parity 1 is correct and 0 is wrong.
    EPS = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    n_chk++; if (PE !== 1'b1) begin n_fail++; $display("FAIL 7o1_pe_bad: got %b want 1", PE); end
  endtask

  task automatic test_5bit_stick();
    WLS = 2'b00; PEN = 1'b1; EPS = 1'b0; SP = 1'b1;
    // Config is changed after the start bit; the latched 5-bit parity setup must win.
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++; if (DOUT !== 8'h1F) begin n_fail++; $display("FAIL 5bit_dout: got %h want 1f", DOUT); end
    n_chk++; if (PE !== 1'b0) begin n_fail++; $display("FAIL 5bit_pe: got %b want 0", PE); end
    n_chk++; if (FE !== 1'b0) begin n_fail++; $display("FAIL 5bit_fe: got %b want 0", FE); end
  endtask

  task automatic test_glitch();
    int f0;
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    f0 = fin_cnt;
    SIN = 1'b0;
    ticks(4);
    SIN = 1'b1;
    ticks(200);
    n_chk++; if (fin_cnt != f0) begin n_fail++; $display("FAIL glitch_pulse: got %0d want 0", fin_cnt - f0); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (DOUT !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_dout: got %h want 3c", DOUT); end
    n_chk++; if (fin_cnt - f0 != 1) begin n_fail++; $display("FAIL glitch_next_pulses: got %0d want 1", fin_cnt - f0); end
  endtask

  task automatic test_framing_break();
    int f0;
    WLS = 2'b11; PEN = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (DOUT !== 8'h55) begin n_fail++; $display("FAIL fe_dout: got %h want 55", DOUT); end
    n_chk++; if (FE !== 1'b1) begin n_fail++; $display("FAIL fe_fe: got %b want 1", FE); end
    n_chk++; if (BI !== 1'b0) begin n_fail++; $display("FAIL fe_bi: got %b want 0", BI); end
    ticks(20);
    f0 = fin_cnt;
    SIN = 1'b0;
    st = cur_tick + 1;
    ticks(480);
    n_chk++; if (fin_cnt - f0 != 1) begin n_fail++; $display("FAIL brk_pulses: got %0d want 1", fin_cnt - f0); end
    n_chk++; if (fin_tick - st != 152) begin n_fail++; $display("FAIL brk_latency: got %0d want 152", fin_tick - st); end
    n_chk++; if ({DOUT, FE, BI} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL brk_out: got %h/%b%b want 00/11", DOUT, FE, BI); end
    SIN = 1'b1;
    ticks(40);
    n_chk++; if (fin_cnt - f0 != 1) begin n_fail++; $display("FAIL brk_release: got %0d want 1", fin_cnt - f0); end
  endtask

  task automatic test_rxclear();
    int f0;
    f0 = fin_cnt;
    SIN = 1'b0;
    ticks(16);
    SIN = 1'b1; ticks(16);
    SIN = 1'b0; ticks(16);
    SIN = 1'b1; ticks(8);
    // Abort lands on an RXCLK cycle to exercise priority.
    @(negedge CLK);
    cur_tick = cur_tick + 1;
    RXCLK = 1'b1; RXCLEAR = 1'b1;
    @(negedge CLK);
    RXCLK = 1'b0; RXCLEAR = 1'b0;
    ticks(200);
    n_chk++; if (fin_cnt != f0) begin n_fail++; $display("FAIL clr_pulse: got %0d want 0", fin_cnt - f0); end
    n_chk++; if ({DOUT, FE, BI} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL clr_hold: got %h/%b%b want 00/11", DOUT, FE, BI); end
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++; if ({DOUT, PE, FE, BI} !== {8'hC3, 3'b000}) begin n_fail++; $display("FAIL clr_next: got %h/%b%b%b want c3/000", DOUT, PE, FE, BI); end
  endtask

  task automatic test_rst_parity();
    WLS = 2'b10; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
    SIN = 1'b0; ticks(16);
    for (int i = 0; i < 7; i++) begin
      SIN = (i == 0); ticks(16);
    end
    SIN = 1'b1; ticks(8);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_chk++; if ({DOUT, PE, FE, BI, RXFINISHED} !== 12'h000) begin n_fail++; $display("FAIL rst_mid: got %h/%b%b%b%b want 00/0000", DOUT, PE, FE, BI, RXFINISHED); end
    RST = 1'b0;
    WLS = 2'b11; PEN = 1'b0;
    ticks(4);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (DOUT !== 8'h81) begin n_fail++; $display("FAIL rst_next_dout: got %h want 81", DOUT); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_5bit_stick();
    test_glitch();
    test_framing_break();
    test_rxclear();
    test_rst_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
